// File: rtl/simmem_pkg.sv
// Shared types and constants for the simulated memory controller.
// Holds the write-address/response bundles and the responder FSM states.
package simmem_pkg;

    localparam int IDWidth   = 6;
    localparam int AddrWidth = 32;

    localparam logic [1:0] RspOkay = 2'b00;

    typedef struct packed {
        logic [IDWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
    } waddr_t;

    typedef struct packed {
        logic [IDWidth-1:0] id;
        logic [1:0]         rsp;
    } wresp_t;

    typedef enum logic [1:0] {
        WrespIdle = 2'd0,
        WrespWait = 2'd1,
        WrespResp = 2'd2
    } wresp_state_e;

endpackage

// File: rtl/simmem_id_fifo.sv
// Circular ID FIFO with valid/ready on both sides and no push bypass.
// Storage is not reset; only pointers and count are.
module simmem_id_fifo #(
    parameter int Depth = 8,
    parameter int Width = 6
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_valid_i,
    output logic                       push_ready_o,
    input  logic [Width-1:0]           push_data_i,
    output logic                       pop_valid_o,
    input  logic                       pop_ready_i,
    output logic [Width-1:0]           pop_data_o,
    output logic [$clog2(Depth+1)-1:0] count_o
);

    localparam int PtrW = $clog2(Depth);
    localparam int CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, wptr_d;
    logic [PtrW-1:0]  rptr_q, rptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push_hs;
    logic             pop_hs;

    assign push_ready_o = (count_q != CntW'(Depth));
    assign pop_valid_o  = (count_q != '0);
    assign pop_data_o   = mem_q[rptr_q];
    assign count_o      = count_q;
    assign push_hs      = push_valid_i & push_ready_o;
    assign pop_hs       = pop_valid_o & pop_ready_i;

    // Advance pointers with explicit wrap and track occupancy.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_hs) begin
            wptr_d = (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + PtrW'(1);
        end
        if (pop_hs) begin
            rptr_d = (rptr_q == PtrW'(Depth - 1)) ? '0 : rptr_q + PtrW'(1);
        end
        unique case ({push_hs, pop_hs})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Entry storage, written only on an accepted push.
    always_ff @(posedge clk_i) begin
        if (push_hs) begin
            mem_q[wptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/simmem_wresp_responder.sv
// Write-response responder: queues write IDs and answers each one in
// order, a fixed latency after it reaches the head of the queue.
module simmem_wresp_responder
    import simmem_pkg::*;
#(
    parameter int QueueDepth  = 8,
    parameter int RespLatency = 4
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   waddr_in_valid_i,
    output logic   waddr_in_ready_o,
    input  waddr_t waddr_data_i,
    output logic   wresp_out_valid_o,
    input  logic   wresp_out_ready_i,
    output wresp_t wresp_data_o
);

    localparam int CntW = $clog2(QueueDepth + 1);
    localparam int DlyW = $clog2(RespLatency + 1);

    localparam logic [DlyW-1:0] DlyLoad = DlyW'(RespLatency - 1);
    localparam wresp_state_e ArmState =
        (RespLatency == 1) ? WrespResp : WrespWait;

    wresp_state_e       state_q, state_d;
    logic [DlyW-1:0]    dly_q, dly_d;
    logic               head_valid;
    logic               head_ready;
    logic [IDWidth-1:0] head_id;
    logic [CntW-1:0]    count;
    logic [CntW-1:0]    count_after;
    logic               push_hs;
    logic               pop_hs;
    logic               unused_waddr;

    assign unused_waddr = ^{waddr_data_i.addr, waddr_data_i.len,
                            waddr_data_i.size, waddr_data_i.burst};

    simmem_id_fifo #(
        .Depth (QueueDepth),
        .Width (IDWidth)
    ) u_id_fifo (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .push_valid_i (waddr_in_valid_i),
        .push_ready_o (waddr_in_ready_o),
        .push_data_i  (waddr_data_i.id),
        .pop_valid_o  (head_valid),
        .pop_ready_i  (head_ready),
        .pop_data_o   (head_id),
        .count_o      (count)
    );

    assign wresp_out_valid_o = (state_q == WrespResp) & head_valid;
    assign head_ready        = (state_q == WrespResp) & wresp_out_ready_i;
    assign push_hs           = waddr_in_valid_i & waddr_in_ready_o;
    assign pop_hs            = wresp_out_valid_o & wresp_out_ready_i;

    // Occupancy as it will be after this cycle's handshakes.
    always_comb begin
        count_after = count;
        unique case ({push_hs, pop_hs})
            2'b10:   count_after = count + CntW'(1);
            2'b01:   count_after = count - CntW'(1);
            default: count_after = count;
        endcase
    end

    // Response payload; zero outside RESP so stale storage never leaks.
    always_comb begin
        wresp_data_o = '0;
        if (wresp_out_valid_o) begin
            wresp_data_o.id  = head_id;
            wresp_data_o.rsp = RspOkay;
        end
    end

    // Head FSM: arm the latency countdown, present, then re-arm or idle.
    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        unique case (state_q)
            WrespIdle: begin
                if (push_hs) begin
                    state_d = ArmState;
                    dly_d   = DlyLoad;
                end
            end
            WrespWait: begin
                if (dly_q <= DlyW'(1)) begin
                    state_d = WrespResp;
                    dly_d   = '0;
                end else begin
                    dly_d = dly_q - DlyW'(1);
                end
            end
            WrespResp: begin
                if (pop_hs) begin
                    if (count_after != '0) begin
                        state_d = ArmState;
                        dly_d   = DlyLoad;
                    end else begin
                        state_d = WrespIdle;
                        dly_d   = '0;
                    end
                end
            end
            default: begin
                state_d = WrespIdle;
                dly_d   = '0;
            end
        endcase
    end

    // FSM state and delay counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= WrespIdle;
            dly_q   <= '0;
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
        end
    end

endmodule
